img_rsz_pxl_fwd: RTL and testbench
==================================

# img_rsz_pxl_fwd

Resized-pixel forwarder at the output end of the image resizer. It accepts one accumulated block (per-colour sums plus pixel count) at a time from the resizer compute engine and averages it with an iterative divider. It then emits the averaged pixel with its resized-image coordinates on a valid/ready stream. Each accepted output pixel pulses `FwdRszEn` back to the image-capture side, and the last pixel of a resized frame pulses `RszImgComp`.

## Interface
Parameters:
- `PRIM_COLOR_W`, default 8: bits per primary colour.
- `PRIM_COLOR_NUM`, default 3: number of primary colours.
- `CNT_W`, default 9: width of the block pixel count; supports blocks up to 256 pixels.
- `SUM_W`, default `PRIM_COLOR_W+CNT_W`: width of a per-colour block sum.
- `RSZ_WIDTH`, default 32: resized image width. Power of 2, at least 2.
- `RSZ_HEIGHT`, default 32: resized image height. Power of 2, at least 2.
- `X_W` / `Y_W`, defaults `$clog2(RSZ_WIDTH)` / `$clog2(RSZ_HEIGHT)`: coordinate widths.

Ports:
- `Clk` in 1: clock.
- `Reset` in 1: reset. Synchronous, active-high.
- `BlkSum` in `SUM_W` x `PRIM_COLOR_NUM`: per-colour block sum.
- `BlkCnt` in `CNT_W`: number of pixels in the block.
- `BlkVld` in 1: block valid.
- `BlkRdy` out 1: block ready.
- `RszPxlData` out `PRIM_COLOR_W` x `PRIM_COLOR_NUM`: averaged pixel.
- `RszPxlX` out `X_W`: resized column of the pixel.
- `RszPxlY` out `Y_W`: resized row of the pixel.
- `RszPxlVld` out 1: output valid.
- `RszPxlRdy` in 1: output ready.
- `FwdRszEn` out 1: one-cycle pulse per output handshake.
- `RszImgComp` out 1: one-cycle pulse on the handshake of the last pixel of a frame.
- `DivZeroErr` out 1: one-cycle pulse when a block with `BlkCnt==0` is accepted.

## Operation
- FSM states: IDLE, DIV, OUT. Reset state is IDLE.
- IDLE:
  - `BlkRdy=1`.
  - On `BlkVld&BlkRdy`: latch the sums and count and clear the quotient/remainder registers.
  - If `BlkCnt!=0`: go to DIV with iteration counter = `SUM_W-1`.
  - If `BlkCnt==0`: force all quotients to 0, pulse `DivZeroErr`, go directly to OUT.
- DIV:
  - Restoring division, one quotient bit per cycle, MSB first, all colours in parallel under shared control.
  - Each cycle: rem = {rem, next sum bit}; if rem >= cnt then rem -= cnt and the quotient bit is 1.
  - Remainder width `CNT_W+1`.
  - After the iteration at counter 0, go to OUT.
- Output saturation: if a quotient exceeds `2^PRIM_COLOR_W-1`, `RszPxlData` is saturated to all-ones. This happens only with inconsistent input sums.
- OUT:
  - `RszPxlVld=1`. Data, X and Y are held stable until `RszPxlRdy`.
  - On handshake: pulse `FwdRszEn` and go to IDLE.
- Coordinates:
  - X increments on each output handshake.
  - At `RSZ_WIDTH-1`, X wraps to 0 and Y increments.
  - At X=`RSZ_WIDTH-1` and Y=`RSZ_HEIGHT-1`, both wrap to 0 and `RszImgComp` pulses with `FwdRszEn`.
- `BlkRdy` is 0 in DIV and OUT; no new block is accepted until the current pixel has left.

## Timing
- Reset values:
  - State IDLE, X=0, Y=0.
  - `BlkRdy=1`.
  - `RszPxlVld=0`, `RszPxlData=0`, `FwdRszEn=0`, `RszImgComp=0`, `DivZeroErr=0`.
- Latency:
  - Block handshake in cycle T gives `RszPxlVld=1` in cycle T+1+`SUM_W` (T+1 when `BlkCnt==0`).
  - With `RszPxlRdy` tied high, throughput is one pixel per `SUM_W+2` cycles.
- `FwdRszEn`, `RszImgComp` and `DivZeroErr` are registered pulses of exactly one cycle.
  - `FwdRszEn` and `RszImgComp` are asserted in the cycle after the output handshake.
  - `DivZeroErr` is asserted in the cycle after the block handshake.
- Output backpressure holds OUT indefinitely; `RszPxlData`, `RszPxlX` and `RszPxlY` must not change.
- Reset asserted in any state aborts the division, drops `RszPxlVld` and clears the coordinates the next cycle. No pulse is generated for the aborted pixel.

## Configuration
- Macro: `IMG_RSZ_FWD_ROUND_EN`.
- Defined: the latched sum is replaced by sum + (`BlkCnt>>1`) before division, giving round-to-nearest. The latched sum is widened by 1 bit and DIV takes `SUM_W+1` cycles.
- Undefined: truncating division, `SUM_W` DIV cycles.

## Test plan
- Single block, sum {1020,510,0}, cnt 4, `RszPxlRdy`=1:
  - Output {255,127,0}, X=0, Y=0.
  - `RszPxlVld` rises exactly `SUM_W+1` cycles after the handshake.
  - With rounding enabled, the output is {255,128,0}.
- Full frame of 32x32 blocks with cnt 1 and sum = index mod 256:
  - Data equals the index.
  - X/Y walk row-major.
  - `RszImgComp` pulses only with pixel 1023; coordinates then return to 0,0.
- `BlkCnt`=0:
  - `DivZeroErr` pulses once.
  - Output is all zeros after 1 cycle.
  - Coordinates still advance.
- Random `RszPxlRdy` (50%):
  - Data and coordinates stay stable while stalled.
  - `BlkRdy` stays 0 throughout.
  - Exactly one `FwdRszEn` per handshake.
- Reset asserted mid-DIV and again mid-OUT stall:
  - Next cycle `RszPxlVld`=0 and X=Y=0.
  - No `FwdRszEn` for the aborted pixel.
  - The next block is processed normally.

Source files
------------

// File: rtl/img_rsz_pxl_fwd_if.sv
// img_rsz_pxl_fwd_if
// Bundles the block-input stream, the resized-pixel output stream and the
// status pulses of the resized-pixel forwarder.
//   slave  : forwarder side (consumes blocks, produces pixels and pulses)
//   master : environment side (produces blocks, consumes pixels and pulses)
// Signals:
//   BlkSum/BlkCnt/BlkVld/BlkRdy             block input handshake
//   RszPxlData/RszPxlX/RszPxlY/Vld/Rdy      pixel output handshake
//   FwdRszEn/RszImgComp/DivZeroErr          one-cycle status pulses
interface img_rsz_pxl_fwd_if #(
  parameter int PRIM_COLOR_W   = 8,
  parameter int PRIM_COLOR_NUM = 3,
  parameter int CNT_W          = 9,
  parameter int SUM_W          = PRIM_COLOR_W + CNT_W,
  parameter int RSZ_WIDTH      = 32,
  parameter int RSZ_HEIGHT     = 32,
  parameter int X_W            = $clog2(RSZ_WIDTH),
  parameter int Y_W            = $clog2(RSZ_HEIGHT)
);
  logic [PRIM_COLOR_NUM-1:0][SUM_W-1:0]        BlkSum;
  logic [CNT_W-1:0]                            BlkCnt;
  logic                                        BlkVld;
  logic                                        BlkRdy;
  logic [PRIM_COLOR_NUM-1:0][PRIM_COLOR_W-1:0] RszPxlData;
  logic [X_W-1:0]                              RszPxlX;
  logic [Y_W-1:0]                              RszPxlY;
  logic                                        RszPxlVld;
  logic                                        RszPxlRdy;
  logic                                        FwdRszEn;
  logic                                        RszImgComp;
  logic                                        DivZeroErr;

  modport slave (
    input  BlkSum, BlkCnt, BlkVld, RszPxlRdy,
    output BlkRdy, RszPxlData, RszPxlX, RszPxlY, RszPxlVld,
           FwdRszEn, RszImgComp, DivZeroErr
  );

  modport master (
    output BlkSum, BlkCnt, BlkVld, RszPxlRdy,
    input  BlkRdy, RszPxlData, RszPxlX, RszPxlY, RszPxlVld,
           FwdRszEn, RszImgComp, DivZeroErr
  );
endinterface

// File: rtl/img_rsz_pxl_fwd.sv
// img_rsz_pxl_fwd
// Resized-pixel forwarder: accepts one accumulated block (per-colour sums and
// pixel count), averages it with a restoring divider (one quotient bit per
// cycle, all colours in parallel), and emits the averaged pixel with its
// resized-image coordinates on a valid/ready stream.
// Ports:
//   Clk    clock
//   Reset  synchronous, active-high reset
//   Bus    img_rsz_pxl_fwd_if.slave: block input, pixel output, pulses
// Optional feature: define IMG_RSZ_FWD_ROUND_EN for round-to-nearest
// averaging (sum + cnt/2 before division, one extra divide cycle).
module img_rsz_pxl_fwd #(
  parameter int PRIM_COLOR_W   = 8,
  parameter int PRIM_COLOR_NUM = 3,
  parameter int CNT_W          = 9,
  parameter int SUM_W          = PRIM_COLOR_W + CNT_W,
  parameter int RSZ_WIDTH      = 32,
  parameter int RSZ_HEIGHT     = 32,
  parameter int X_W            = $clog2(RSZ_WIDTH),
  parameter int Y_W            = $clog2(RSZ_HEIGHT)
) (
  input logic              Clk,
  input logic              Reset,
  img_rsz_pxl_fwd_if.slave Bus
);

`ifdef IMG_RSZ_FWD_ROUND_EN
  localparam int DIV_W = SUM_W + 1;
`else
  localparam int DIV_W = SUM_W;
`endif
  localparam int CTR_W = $clog2(DIV_W);

  typedef enum logic [1:0] {IDLE = 2'd0, DIV = 2'd1, OUT = 2'd2} state_t;

  state_t                                      stateReg, stateNxt;
  logic [PRIM_COLOR_NUM-1:0][DIV_W-1:0]        sumReg, sumNxt;
  logic [PRIM_COLOR_NUM-1:0][DIV_W-1:0]        quotReg, quotNxt;
  logic [PRIM_COLOR_NUM-1:0][CNT_W:0]          remReg, remNxt;
  logic [PRIM_COLOR_NUM-1:0][CNT_W+1:0]        remSh;
  logic [CNT_W-1:0]                            cntReg, cntNxt;
  logic [CTR_W-1:0]                            ctrReg, ctrNxt;
  logic [PRIM_COLOR_NUM-1:0][PRIM_COLOR_W-1:0] dataReg, dataNxt;
  logic [X_W-1:0]                              xReg, xNxt;
  logic [Y_W-1:0]                              yReg, yNxt;
  logic                                        blkRdyReg, vldReg;
  logic                                        fwdEnReg, compReg, divZeroReg;
  logic                                        blkAccept, pxlHshk, lastPxl;

  // Clamp a quotient to the colour range; only inconsistent sums exceed it.
  function automatic logic [PRIM_COLOR_W-1:0] satPxl(input logic [DIV_W-1:0] q);
    if (q > DIV_W'({PRIM_COLOR_W{1'b1}})) begin
      return {PRIM_COLOR_W{1'b1}};
    end else begin
      return q[PRIM_COLOR_W-1:0];
    end
  endfunction

  // Next-state, datapath and coordinate logic.
  always_comb begin
    stateNxt  = stateReg;
    sumNxt    = sumReg;
    quotNxt   = quotReg;
    remNxt    = remReg;
    remSh     = '0;
    cntNxt    = cntReg;
    ctrNxt    = ctrReg;
    dataNxt   = dataReg;
    xNxt      = xReg;
    yNxt      = yReg;
    blkAccept = 1'b0;
    pxlHshk   = 1'b0;
    lastPxl   = 1'b0;
    case (stateReg)
      IDLE: begin
        if (Bus.BlkVld && blkRdyReg) begin
          blkAccept = 1'b1;
          for (int c = 0; c < PRIM_COLOR_NUM; c++) begin
`ifdef IMG_RSZ_FWD_ROUND_EN
            sumNxt[c] = DIV_W'(Bus.BlkSum[c]) + DIV_W'(Bus.BlkCnt[CNT_W-1:1]);
`else
            sumNxt[c] = Bus.BlkSum[c];
`endif
          end
          quotNxt = '0;
          remNxt  = '0;
          cntNxt  = Bus.BlkCnt;
          if (Bus.BlkCnt != {CNT_W{1'b0}}) begin
            stateNxt = DIV;
            ctrNxt   = CTR_W'(DIV_W - 1);
          end else begin
            // Empty block: skip the divider and emit black.
            stateNxt = OUT;
            dataNxt  = '0;
          end
        end else begin
          stateNxt = IDLE;
        end
      end
      DIV: begin
        for (int c = 0; c < PRIM_COLOR_NUM; c++) begin
          remSh[c] = {remReg[c], sumReg[c][ctrReg]};
          if (remSh[c] >= (CNT_W+2)'(cntReg)) begin
            remNxt[c]  = (CNT_W+1)'(remSh[c] - (CNT_W+2)'(cntReg));
            quotNxt[c] = DIV_W'({quotReg[c], 1'b1});
          end else begin
            remNxt[c]  = (CNT_W+1)'(remSh[c]);
            quotNxt[c] = DIV_W'({quotReg[c], 1'b0});
          end
        end
        if (ctrReg == {CTR_W{1'b0}}) begin
          stateNxt = OUT;
          for (int c = 0; c < PRIM_COLOR_NUM; c++) begin
            dataNxt[c] = satPxl(quotNxt[c]);
          end
        end else begin
          ctrNxt = ctrReg - {{(CTR_W-1){1'b0}}, 1'b1};
        end
      end
      OUT: begin
        if (Bus.RszPxlRdy) begin
          pxlHshk  = 1'b1;
          stateNxt = IDLE;
          if (xReg == X_W'(RSZ_WIDTH - 1)) begin
            xNxt = '0;
            if (yReg == Y_W'(RSZ_HEIGHT - 1)) begin
              yNxt    = '0;
              lastPxl = 1'b1;
            end else begin
              yNxt = yReg + {{(Y_W-1){1'b0}}, 1'b1};
            end
          end else begin
            xNxt = xReg + {{(X_W-1){1'b0}}, 1'b1};
          end
        end else begin
          stateNxt = OUT;
        end
      end
      default: begin
        stateNxt = IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      stateReg   <= IDLE;
      sumReg     <= '0;
      quotReg    <= '0;
      remReg     <= '0;
      cntReg     <= '0;
      ctrReg     <= '0;
      dataReg    <= '0;
      xReg       <= '0;
      yReg       <= '0;
      blkRdyReg  <= 1'b1;
      vldReg     <= 1'b0;
      fwdEnReg   <= 1'b0;
      compReg    <= 1'b0;
      divZeroReg <= 1'b0;
    end else begin
      stateReg   <= stateNxt;
      sumReg     <= sumNxt;
      quotReg    <= quotNxt;
      remReg     <= remNxt;
      cntReg     <= cntNxt;
      ctrReg     <= ctrNxt;
      dataReg    <= dataNxt;
      xReg       <= xNxt;
      yReg       <= yNxt;
      blkRdyReg  <= (stateNxt == IDLE);
      vldReg     <= (stateNxt == OUT);
      fwdEnReg   <= pxlHshk;
      compReg    <= pxlHshk && lastPxl;
      divZeroReg <= blkAccept && (Bus.BlkCnt == {CNT_W{1'b0}});
    end
  end

  assign Bus.BlkRdy     = blkRdyReg;
  assign Bus.RszPxlVld  = vldReg;
  assign Bus.RszPxlData = dataReg;
  assign Bus.RszPxlX    = xReg;
  assign Bus.RszPxlY    = yReg;
  assign Bus.FwdRszEn   = fwdEnReg;
  assign Bus.RszImgComp = compReg;
  assign Bus.DivZeroErr = divZeroReg;

endmodule

// File: tb/tb_img_rsz_pxl_fwd.sv
// Self-checking bench for img_rsz_pxl_fwd: table of directed blocks with
// hand-computed averages, random output backpressure, reset aborts and a
// full 32x32 frame walk.
module tb_img_rsz_pxl_fwd;
  localparam int PW    = 8;
  localparam int CNT_W = 9;
  localparam int SUM_W = PW + CNT_W;
  localparam int W     = 32;
  localparam int H     = 32;
`ifdef IMG_RSZ_FWD_ROUND_EN
  localparam int DIV_W = SUM_W + 1;
`else
  localparam int DIV_W = SUM_W;
`endif

  typedef struct {
    int s0, s1, s2, cnt;
    int e0, e1, e2;
  } vec_t;

  logic Clk = 1'b0;
  logic Reset;
  int   compared = 0;
  int   mismatched = 0;
  int   xExp = 0;
  int   yExp = 0;
  vec_t vecs[6];

  img_rsz_pxl_fwd_if #(.PRIM_COLOR_W(PW), .PRIM_COLOR_NUM(3), .CNT_W(CNT_W),
                       .RSZ_WIDTH(W), .RSZ_HEIGHT(H)) busIf ();

  img_rsz_pxl_fwd dut (.Clk(Clk), .Reset(Reset), .Bus(busIf));

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int pack3(input int e0, input int e1, input int e2);
    return (e2 << 16) | (e1 << 8) | e0;
  endfunction

  task automatic advanceXY();
    xExp = (xExp + 1) % W;
    if (xExp == 0) yExp = (yExp + 1) % H;
  endtask

  // Handshake one block and wait (bounded) for the pixel; returns latency
  // counted from the cycle after the handshake.
  task automatic sendBlock(input int s0, input int s1, input int s2, input int c,
                           output int lat);
    chk("blkRdy_before", int'(busIf.BlkRdy), 1);
    busIf.BlkSum[0] = SUM_W'(s0);
    busIf.BlkSum[1] = SUM_W'(s1);
    busIf.BlkSum[2] = SUM_W'(s2);
    busIf.BlkCnt    = CNT_W'(c);
    busIf.BlkVld    = 1'b1;
    tick();
    busIf.BlkVld = 1'b0;
    chk("divZeroErr", int'(busIf.DivZeroErr), (c == 0) ? 1 : 0);
    lat = 0;
    while (!busIf.RszPxlVld && lat < 200) begin
      tick();
      lat++;
    end
  endtask

  // Check the presented pixel, then take it with a one-cycle ready.
  task automatic takePixel(input int expData, input int expComp);
    chk("data", int'(busIf.RszPxlData), expData);
    chk("x", int'(busIf.RszPxlX), xExp);
    chk("y", int'(busIf.RszPxlY), yExp);
    busIf.RszPxlRdy = 1'b1;
    tick();
    busIf.RszPxlRdy = 1'b0;
    chk("fwdRszEn", int'(busIf.FwdRszEn), 1);
    chk("rszImgComp", int'(busIf.RszImgComp), expComp);
    chk("vld_after_hs", int'(busIf.RszPxlVld), 0);
    advanceXY();
    tick();
    chk("fwdRszEn_width", int'(busIf.FwdRszEn), 0);
  endtask

  initial begin
    int lat;
    int hs;
    int pulses;
    int expD;

`ifdef IMG_RSZ_FWD_ROUND_EN
    vecs[0] = '{1020, 510, 0, 4, 255, 128, 0};
    vecs[1] = '{100, 200, 300, 3, 33, 67, 100};
    vecs[2] = '{65280, 0, 128, 256, 255, 0, 1};
    vecs[5] = '{7, 8, 12, 5, 1, 2, 2};
`else
    vecs[0] = '{1020, 510, 0, 4, 255, 127, 0};
    vecs[1] = '{100, 200, 300, 3, 33, 66, 100};
    vecs[2] = '{65280, 0, 128, 256, 255, 0, 0};
    vecs[5] = '{7, 8, 12, 5, 1, 1, 2};
`endif
    vecs[3] = '{50, 60, 70, 0, 0, 0, 0};
    vecs[4] = '{600, 7, 256, 1, 255, 7, 255};

    Reset = 1'b1;
    busIf.BlkVld = 1'b0;
    busIf.BlkSum = '0;
    busIf.BlkCnt = '0;
    busIf.RszPxlRdy = 1'b0;
    tick();
    tick();
    Reset = 1'b0;
    chk("rst_blkRdy", int'(busIf.BlkRdy), 1);
    chk("rst_vld", int'(busIf.RszPxlVld), 0);
    chk("rst_data", int'(busIf.RszPxlData), 0);
    chk("rst_fwd", int'(busIf.FwdRszEn), 0);
    chk("rst_comp", int'(busIf.RszImgComp), 0);
    chk("rst_err", int'(busIf.DivZeroErr), 0);
    chk("rst_x", int'(busIf.RszPxlX), 0);
    chk("rst_y", int'(busIf.RszPxlY), 0);

    // Directed table.
    for (int i = 0; i < 6; i++) begin
      sendBlock(vecs[i].s0, vecs[i].s1, vecs[i].s2, vecs[i].cnt, lat);
      chk("latency", lat, (vecs[i].cnt == 0) ? 0 : DIV_W);
      chk("blkRdy_in_out", int'(busIf.BlkRdy), 0);
      takePixel(pack3(vecs[i].e0, vecs[i].e1, vecs[i].e2), 0);
    end

    // Random backpressure: outputs frozen, no new block, one pulse each.
    for (int k = 0; k < 4; k++) begin
      sendBlock(vecs[k % 3].s0, vecs[k % 3].s1, vecs[k % 3].s2, vecs[k % 3].cnt, lat);
      chk("stall_latency", lat, DIV_W);
      expD = pack3(vecs[k % 3].e0, vecs[k % 3].e1, vecs[k % 3].e2);
      hs = 0;
      for (int j = 0; j < 60 && hs == 0; j++) begin
        busIf.RszPxlRdy = (j == 59) ? 1'b1 : 1'($urandom_range(0, 1));
        tick();
        if (busIf.FwdRszEn) begin
          hs = 1;
        end else begin
          chk("stall_vld", int'(busIf.RszPxlVld), 1);
          chk("stall_data", int'(busIf.RszPxlData), expD);
          chk("stall_x", int'(busIf.RszPxlX), xExp);
          chk("stall_y", int'(busIf.RszPxlY), yExp);
          chk("stall_blkRdy", int'(busIf.BlkRdy), 0);
        end
      end
      busIf.RszPxlRdy = 1'b0;
      chk("stall_hs", hs, 1);
      advanceXY();
      tick();
      chk("stall_single_pulse", int'(busIf.FwdRszEn), 0);
    end

    // Reset mid-DIV.
    busIf.BlkSum[0] = SUM_W'(400);
    busIf.BlkSum[1] = SUM_W'(40);
    busIf.BlkSum[2] = SUM_W'(4);
    busIf.BlkCnt = CNT_W'(2);
    busIf.BlkVld = 1'b1;
    tick();
    busIf.BlkVld = 1'b0;
    repeat (4) tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    xExp = 0;
    yExp = 0;
    chk("rstdiv_vld", int'(busIf.RszPxlVld), 0);
    chk("rstdiv_x", int'(busIf.RszPxlX), 0);
    chk("rstdiv_y", int'(busIf.RszPxlY), 0);
    chk("rstdiv_blkRdy", int'(busIf.BlkRdy), 1);
    pulses = 0;
    for (int j = 0; j < DIV_W + 4; j++) begin
      tick();
      pulses += int'(busIf.FwdRszEn) + int'(busIf.RszPxlVld);
    end
    chk("rstdiv_no_pulse", pulses, 0);

    // One normal pixel so coordinates are non-zero, then reset in OUT stall.
    sendBlock(9, 18, 27, 9, lat);
    takePixel(pack3(1, 2, 3), 0);
    sendBlock(400, 40, 4, 2, lat);
    chk("rstout_latency", lat, DIV_W);
    repeat (3) tick();
    chk("rstout_stall_vld", int'(busIf.RszPxlVld), 1);
    busIf.RszPxlRdy = 1'b1;
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    busIf.RszPxlRdy = 1'b0;
    xExp = 0;
    yExp = 0;
    chk("rstout_vld", int'(busIf.RszPxlVld), 0);
    chk("rstout_x", int'(busIf.RszPxlX), 0);
    chk("rstout_y", int'(busIf.RszPxlY), 0);
    chk("rstout_fwd", int'(busIf.FwdRszEn), 0);
    tick();
    chk("rstout_fwd_late", int'(busIf.FwdRszEn), 0);
    sendBlock(400, 40, 4, 2, lat);
    chk("post_rst_latency", lat, DIV_W);
    takePixel(pack3(200, 20, 2), 0);

    // Full frame, cnt 1, coordinates restart from a fresh reset.
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    xExp = 0;
    yExp = 0;
    for (int i = 0; i < W * H; i++) begin
      sendBlock(i % 256, 255 - (i % 256), i / 4, 1, lat);
      chk("frame_latency", lat, DIV_W);
      takePixel(pack3(i % 256, 255 - (i % 256), i / 4), (i == W * H - 1) ? 1 : 0);
    end
    chk("frame_end_x", int'(busIf.RszPxlX), 0);
    chk("frame_end_y", int'(busIf.RszPxlY), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
